// File: rtl/autoindex_pkg.sv
// autoindex_pkg: shared states, widths and pointer-page constant for the autoindex sequencer
package autoindex_pkg;
   localparam int ADDR_W = 16;
   localparam int OPERAND_W = 10;
   localparam logic [ADDR_W-OPERAND_W-1:0] AI_PAGE = '0;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} st_e;
   function automatic logic [ADDR_W-1:0] ptr_addr(input logic [OPERAND_W-1:0] op);
      return {AI_PAGE, op};
   endfunction
endpackage

// File: rtl/ai_incr.sv
// ai_incr: 16-bit wrap-around incrementer producing the autoindex write-back value
module ai_incr
   import autoindex_pkg::*;
(
   input  logic [ADDR_W-1:0] a,
   output logic [ADDR_W-1:0] y
);
   assign y = a + ADDR_W'(1);
endmodule

// File: rtl/autoindex_seq.sv
// autoindex_seq: resolves an indirect operand by reading its pointer and, when autoindexed,
// writing the post-incremented pointer back before signalling done
module autoindex_seq
   import autoindex_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 naindex,
   input  logic                 start,
   input  logic [OPERAND_W-1:0] operand,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [ADDR_W-1:0]    mem_wdata,
   input  logic [ADDR_W-1:0]    mem_rdata,
   input  logic                 mem_ack,
   output logic [ADDR_W-1:0]    ea,
   output logic                 busy,
   output logic                 done
);
   st_e st_q, st_d;
   logic [OPERAND_W-1:0] op_q, op_d;
   logic ai_q, ai_d;
   logic [ADDR_W-1:0] ea_q, ea_d, ea_inc;
   always_comb begin
      st_d = st_q;
      op_d = op_q;
      ai_d = ai_q;
      ea_d = ea_q;
      case (st_q)
         IDLE: if (start) begin
            op_d = operand;
            ai_d = ~naindex;
            st_d = READ;
         end
         READ: if (mem_ack) begin
            ea_d = mem_rdata;
            st_d = ai_q ? WRITE : DONE;
         end
         WRITE: if (mem_ack) st_d = DONE;
         default: st_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q <= IDLE;
         op_q <= '0;
         ai_q <= 1'b0;
         ea_q <= '0;
      end else begin
         st_q <= st_d;
         op_q <= op_d;
         ai_q <= ai_d;
         ea_q <= ea_d;
      end
   end
   ai_incr u_incr (.a(ea_q), .y(ea_inc));
   // strobes decode straight from the state flop so reset drops them without waiting for clk
   assign mem_rd    = st_q == READ;
   assign mem_wr    = st_q == WRITE;
   assign mem_addr  = (mem_rd | mem_wr) ? ptr_addr(op_q) : '0;
   assign mem_wdata = mem_wr ? ea_inc : '0;
   assign ea        = ea_q;
   assign busy      = st_q != IDLE;
   assign done      = st_q == DONE;
endmodule

// File: tb/tb_autoindex_seq.sv
// tb_autoindex_seq: directed vector table plus hand-written reset and start-collision sequences
module tb_autoindex_seq;
   logic clk, reset, naindex, start, mem_rd, mem_wr, mem_ack, busy, done;
   logic [9:0] operand;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, ea;
   int errs = 0;
   int checks = 0;

   autoindex_seq dut (
      .clk(clk), .reset(reset), .naindex(naindex), .start(start), .operand(operand),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ea(ea), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  op;
      logic        nai;
      logic [15:0] rd;
      int          rw;
      int          ww;
      bit          poke;
      bit          wr;
      logic [15:0] wdata;
      logic [15:0] ea;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      int cyc, rc, wc;
      bit got_done, wr_seen;
      @(negedge clk);
      start = 1'b1; operand = v.op; naindex = v.nai;
      cyc = 1; rc = 0; wc = 0; got_done = 0; wr_seen = 0;
      while (!got_done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         start = 1'b0; naindex = ~v.nai; operand = ~v.op;
         mem_ack = 1'b0; mem_rdata = 16'hDEAD;
         chk("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
         if (mem_rd) begin
            chk("rd_addr", mem_addr, {22'b0, v.op});
            if (rc == v.rw) begin mem_ack = 1'b1; mem_rdata = v.rd; end
            rc++;
            if (v.poke) start = 1'b1;
         end else if (mem_wr) begin
            wr_seen = 1;
            chk("wr_addr", mem_addr, {22'b0, v.op});
            chk("wdata", mem_wdata, v.wdata);
            if (wc == v.ww) mem_ack = 1'b1;
            wc++;
            if (v.poke) start = 1'b1;
         end else if (done) got_done = 1;
      end
      start = 1'b0; mem_ack = 1'b0;
      chk("done_seen", got_done, 1);
      chk("latency", cyc, v.lat);
      chk("wr_seen", wr_seen, v.wr);
      chk("ea", ea, v.ea);
      chk("busy_in_done", busy, 1);
      repeat (3) begin
         @(negedge clk);
         chk("idle_done", done, 0);
         chk("idle_busy", busy, 0);
         chk("idle_rd", mem_rd | mem_wr, 0);
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{10'h085, 1'b0, 16'h1234, 0, 0, 0, 1, 16'h1235, 16'h1234, 4};
      vecs[1] = '{10'h085, 1'b1, 16'h4000, 0, 0, 0, 0, 16'h0000, 16'h4000, 3};
      vecs[2] = '{10'h3FF, 1'b0, 16'hFFFF, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 4};
      vecs[3] = '{10'h2A5, 1'b0, 16'h00FF, 3, 3, 0, 1, 16'h0100, 16'h00FF, 10};
      vecs[4] = '{10'h001, 1'b1, 16'h8000, 2, 0, 0, 0, 16'h0000, 16'h8000, 5};
      vecs[5] = '{10'h100, 1'b0, 16'h7FFF, 1, 2, 1, 1, 16'h8000, 16'h7FFF, 7};
      reset = 1'b1; start = 1'b0; naindex = 1'b1; operand = '0; mem_ack = 1'b0; mem_rdata = '0;
      #1;
      chk("rst_rd", mem_rd, 0);
      chk("rst_wr", mem_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ea", ea, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) run(vecs[i]);
      // reset during the second wait cycle of the write-back
      @(negedge clk);
      start = 1'b1; operand = 10'h055; naindex = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("seq_rd", mem_rd, 1);
      mem_ack = 1'b1; mem_rdata = 16'h0BEE;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("seq_wr1", mem_wr, 1);
      @(negedge clk);
      chk("seq_wr2", mem_wr, 1);
      chk("seq_wdata", mem_wdata, 16'h0BEF);
      #2 reset = 1'b1;
      #1;
      chk("async_wr", mem_wr, 0);
      chk("async_busy", busy, 0);
      chk("async_addr", mem_addr, 0);
      chk("async_wdata", mem_wdata, 0);
      chk("async_ea", ea, 0);
      @(negedge clk);
      reset = 1'b0; mem_ack = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_access", mem_rd | mem_wr, 0);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_done", done, 0);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/autoindex_seq.md
AUTOINDEX_SEQ -- requirements
Module: autoindex_seq

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port naindex, input, 1, active-low autoindex flag from the autoindex logic; valid whenever start is high.
REQ-004 SHALL have port start, input, 1, one-cycle request from microcode to resolve an indirect operand.
REQ-005 SHALL have port operand, input, 10, IR[9:0] pointer location, valid with start.
REQ-006 SHALL have port mem_addr, output, 16, memory address.
REQ-007 SHALL have port mem_rd, output, 1, read strobe, active-high.
REQ-008 SHALL have port mem_wr, output, 1, write strobe, active-high.
REQ-009 SHALL have port mem_wdata, output, 16, write data.
REQ-010 SHALL have port mem_rdata, input, 16, read data, valid in the mem_ack cycle of a read.
REQ-011 SHALL have port mem_ack, input, 1, access-complete handshake; any number of wait cycles allowed.
REQ-012 SHALL have port ea, output, 16, resolved effective address.
REQ-013 SHALL have port busy, output, 1, high while a request is in progress.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE and DONE.
REQ-016 SHALL, in IDLE with start=1, latch operand and ~naindex as flag ai, then enter READ on the next edge.
REQ-017 SHALL, in READ, drive mem_addr={6'b0,operand} and mem_rd=1, holding both stable until mem_ack=1.
REQ-018 SHALL, on mem_ack in READ, load ea with mem_rdata, then enter WRITE if ai=1 or DONE if ai=0.
REQ-019 SHALL, in WRITE, drive mem_addr={6'b0,operand}, mem_wdata=ea+1 (16-bit, modulo 2^16) and mem_wr=1, holding all stable until mem_ack=1, then enter DONE.
REQ-020 SHALL leave ea unchanged by the write-back: post-increment semantics, ea equals the pre-increment pointer.
REQ-021 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-022 SHALL wrap 0xFFFF to 0x0000 on write-back, with no carry or flag output.
REQ-023 SHALL ignore start while busy=1; no queuing.
REQ-024 SHALL never assert mem_rd and mem_wr in the same cycle.
REQ-025 SHALL ignore mem_ack in IDLE and DONE.
REQ-026 SHALL assert busy in READ, WRITE and DONE, and deassert it in IDLE.
REQ-027 SHALL give a minimum latency, start to done, of 3 cycles plain indirect or 4 cycles autoindexed, at zero wait states.
REQ-028 SHALL not sample naindex outside the start cycle.

Reset
REQ-029 SHALL, while reset=1, force IDLE with mem_rd=0, mem_wr=0, busy=0, done=0, ea=0, mem_addr=0 and mem_wdata=0, independent of clk.
REQ-030 SHALL, on reset mid-access (READ or WRITE), drop the strobe immediately; no write-back SHALL occur after reset releases.

Structure
REQ-031 SHALL place the state enumeration, ADDR_W=16, OPERAND_W=10 and the autoindex page constant in shared package autoindex_pkg.
REQ-032 SHALL instantiate exactly one sub-module, ai_incr (16-bit combinational incrementer), driving mem_wdata.

Verification
REQ-033 SHALL cover: operand=0x085, naindex=0, rdata=0x1234, ack immediate -> read 0x0085, write 0x1235 to 0x0085, ea=0x1234, done at cycle 4.
REQ-034 SHALL cover: operand=0x085, naindex=1, rdata=0x4000 -> single read, no mem_wr ever, ea=0x4000, done at cycle 3.
REQ-035 SHALL cover: naindex=0, rdata=0xFFFF -> mem_wdata=0x0000, ea=0xFFFF.
REQ-036 SHALL cover: 3 wait cycles on each access -> strobes and address stable throughout, done at cycle 10.
REQ-037 SHALL cover: second start pulses during READ and WRITE -> ignored, exactly one done.
REQ-038 SHALL cover: reset asserted in the 2nd wait cycle of WRITE -> mem_wr low asynchronously; after release, IDLE with no further access.
